// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: off/on/blink/inverted blink/PWM per channel.
// Optional shared breathe mode (mode 5) when LED_PATTERN_BREATHE_EN is defined.
module led_pattern_gen #(
    parameter int NUM_LEDS       = 8,
    parameter int CLK_FREQ       = 24000000,
    parameter int BLINK_FREQ     = 1,
    parameter int PWM_FREQ       = 1000,
    parameter int LED_ACTIVE_LOW = 1,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [10:0]         wr_data,
    input  logic                blink_sync,
    output logic [NUM_LEDS-1:0] led,
    output logic                blink_state
);

    localparam int HALF_RAW = CLK_FREQ / BLINK_FREQ / 2;
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

    localparam int DIV_RAW  = CLK_FREQ / (PWM_FREQ * 256);
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic POL = (LED_ACTIVE_LOW != 0);

    logic [BW-1:0] blink_cnt_reg;
    logic          blink_state_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    pwm_cnt_reg;
    logic          pwm_tick;

    // Shared blink phase; a sync pulse wins over the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_reg   <= '0;
            blink_state_reg <= 1'b0;
        end else if (blink_sync) begin
            blink_cnt_reg   <= '0;
            blink_state_reg <= 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_state_reg <= ~blink_state_reg;
        end else begin
            blink_cnt_reg   <= blink_cnt_reg + 1'b1;
        end
    end

    assign pwm_tick = (presc_reg == PRESC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= 8'd0;
        end else begin
            presc_reg <= pwm_tick ? '0 : presc_reg + 1'b1;
            if (pwm_tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            end
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    logic [7:0] breathe_level_reg;
    logic       breathe_down_reg;

    // Level steps once per PWM frame, bouncing between 0 and 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            breathe_level_reg <= 8'd0;
            breathe_down_reg  <= 1'b0;
        end else if (pwm_tick && pwm_cnt_reg == 8'hFF) begin
            if (!breathe_down_reg) begin
                breathe_level_reg <= breathe_level_reg + 8'd1;
                if (breathe_level_reg == 8'hFE) begin
                    breathe_down_reg <= 1'b1;
                end
            end else begin
                breathe_level_reg <= breathe_level_reg - 8'd1;
                if (breathe_level_reg == 8'h01) begin
                    breathe_down_reg <= 1'b0;
                end
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            logic [2:0] mode_reg;
            logic [7:0] duty_reg;
            logic       lit_next;
            logic       led_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mode_reg <= 3'd0;
                    duty_reg <= 8'd0;
                end else if (wr_en && wr_addr == AW'(gi)) begin
                    mode_reg <= wr_data[10:8];
                    duty_reg <= wr_data[7:0];
                end
            end

            always_comb begin
                lit_next = 1'b0;
                case (mode_reg)
                    3'd1: lit_next = 1'b1;
                    3'd2: lit_next = blink_state_reg;
                    3'd3: lit_next = ~blink_state_reg;
                    3'd4: lit_next = (pwm_cnt_reg < duty_reg);
`ifdef LED_PATTERN_BREATHE_EN
                    3'd5: lit_next = (pwm_cnt_reg < breathe_level_reg);
`endif
                    default: lit_next = 1'b0;
                endcase
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    led_reg <= POL;
                end else begin
                    led_reg <= lit_next ^ POL;
                end
            end

            assign led[gi] = led_reg;
        end
    endgenerate

    assign blink_state = blink_state_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a time-based reference model predicts every cycle,
// a monitor pops and compares; an 8-channel and a 7-channel instance share stimulus.
module tb_led_pattern_gen;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [10:0] wr_data = 11'd0;
    logic       blink_sync = 1'b0;
    logic [7:0] led8;
    logic [6:0] led7;
    logic       bs8, bs7;

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_LEDS(8), .CLK_FREQ(1000), .BLINK_FREQ(50), .PWM_FREQ(3),
                      .LED_ACTIVE_LOW(1)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blink_sync(blink_sync), .led(led8), .blink_state(bs8));

    led_pattern_gen #(.NUM_LEDS(7), .CLK_FREQ(1000), .BLINK_FREQ(50), .PWM_FREQ(3),
                      .LED_ACTIVE_LOW(1)) u_dut7 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blink_sync(blink_sync), .led(led7), .blink_state(bs7));

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: configuration tables plus elapsed-edge counts.
    int mode8[8], duty8[8], mode7[7], duty7[7];
    int k_b;     // edges since last blink anchor (reset or sync)
    int anchor;  // blink phase at the anchor
    int k_p;     // edges since reset

    typedef struct {
        logic [7:0] led8;
        logic [6:0] led7;
        logic       bs;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic blink_of();
        return ((anchor + k_b / HALF) % 2) == 1;
    endfunction

    function automatic int level_of();
        int f;
        f = (k_p / 256) % 510;
        return (f <= 255) ? f : 510 - f;
    endfunction

    function automatic logic lit_of(int m, int d);
        int pc;
        pc = k_p % 256;
        case (m)
            1: return 1'b1;
            2: return blink_of();
            3: return !blink_of();
            4: return pc < d;
`ifdef LED_PATTERN_BREATHE_EN
            5: return pc < level_of();
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin mode8[i] = 0; duty8[i] = 0; end
        for (int i = 0; i < 7; i++) begin mode7[i] = 0; duty7[i] = 0; end
        k_b = 0; k_p = 0; anchor = 0;
        sb_q.delete();
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        int a;
        if (reset_n) begin
            for (int i = 0; i < 8; i++) e.led8[i] = !lit_of(mode8[i], duty8[i]);
            for (int i = 0; i < 7; i++) e.led7[i] = !lit_of(mode7[i], duty7[i]);
            if (wr_en) begin
                a = int'(wr_addr);
                mode8[a] = int'(wr_data[10:8]);
                duty8[a] = int'(wr_data[7:0]);
                if (a < 7) begin
                    mode7[a] = int'(wr_data[10:8]);
                    duty7[a] = int'(wr_data[7:0]);
                end
            end
            k_p++;
            if (blink_sync) begin k_b = 0; anchor = 1; end
            else k_b++;
            e.bs = blink_of();
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("led8", int'(led8), int'(e.led8));
            check("led7", int'(led7), int'(e.led7));
            check("blink_state8", int'(bs8), int'(e.bs));
            check("blink_state7", int'(bs7), int'(e.bs));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int a, int m, int d);
        wr_en = 1'b1;
        wr_addr = a[2:0];
        wr_data = {m[2:0], d[7:0]};
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic mid_reset(string tag);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_led8"}, int'(led8), 8'hFF);
        check({tag, "_led7"}, int'(led7), 7'h7F);
        check({tag, "_bs"}, int'(bs8), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic count_low(int ch, int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (led8[ch] == 1'b0) lows++;
        end
    endtask

    initial begin
        int cnt, prev, same, lows;
        model_reset();
        cyc(3);
        reset_n = 1'b1;
        cyc(20);

        // Asynchronous reset, then idle for 1000 cycles.
        mid_reset("reset1");
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (led8 != 8'hFF) cnt++;
        end
        check("idle_not_ff", cnt, 0);

        // Mode 1 latency: old value at edge N, new value from N+1.
        wr(0, 1, 0);
        check("mode1_edgeN", int'(led8[0]), 1);
        cyc(1);
        check("mode1_edgeN1", int'(led8[0]), 0);

        // Blink and inverted blink.
        wr(1, 2, 0);
        wr(2, 3, 0);
        cyc(2);
        prev = int'(led8[1]);
        cnt = 0; same = 0;
        repeat (40) begin
            @(negedge clk);
            if (int'(led8[1]) != prev) cnt++;
            if (led8[1] == led8[2]) same++;
            prev = int'(led8[1]);
        end
        check("blink_toggles", cnt, 4);
        check("complement_violations", same, 0);

        // Sync pulse coinciding with a terminal count.
        cnt = 0;
        while (k_b % HALF != HALF - 1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("sync_wait_bound", int'(k_b % HALF == HALF - 1), 1);
        blink_sync = 1'b1;
        @(negedge clk);
        blink_sync = 1'b0;
        check("sync_state", int'(bs8), 1);
        cnt = 0;
        while (bs8 == 1'b1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("sync_period", cnt, 10);

        // PWM duty sweep on channel 3.
        wr(3, 4, 64);
        cyc(2);
        count_low(3, 256, lows);
        check("pwm_duty64", lows, 64);
        wr(3, 4, 0);
        cyc(2);
        count_low(3, 256, lows);
        check("pwm_duty0", lows, 0);
        wr(3, 4, 255);
        cyc(2);
        count_low(3, 256, lows);
        check("pwm_duty255", lows, 255);

        // Address beyond the 7-channel instance: only the 8-channel one reacts.
        wr(7, 1, 0);
        cyc(1);
        check("addr7_dut8", int'(led8[7]), 0);
        check("addr7_dut7_ch0", int'(led7[0]), 0);

        // Breathe mode on channel 4.
        wr(4, 5, 200);
        cyc(2);
        count_low(4, 600, lows);
`ifndef LED_PATTERN_BREATHE_EN
        check("mode5_off", lows, 0);
`endif

        // Randomized writes and syncs, checked by the scoreboard.
        repeat (2000) begin
            if ($urandom_range(0, 7) == 0) begin
                wr_en = 1'b1;
                wr_addr = 3'($urandom_range(0, 7));
                wr_data = 11'($urandom);
            end else begin
                wr_en = 1'b0;
            end
            blink_sync = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        blink_sync = 1'b0;

        // Reset in the middle of an active pattern.
        mid_reset("reset2");
        cyc(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
